// File: rtl/bram_qr_pkg.sv
// Shared definitions for the sequence-buffer tile reader: FSM encoding and
// the depth of the read-data skid FIFO.
package bram_qr_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_qr_skid_fifo.sv
// Two-entry FIFO that catches buffer read data so reads can run ahead of a
// stalled consumer by up to FIFO_DEPTH words.
import bram_qr_pkg::*;

module bram_qr_skid_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic                                  wr_ptr, rd_ptr;

  assign valid = (count != 2'd0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_qr_reader.sv
// Streams a tile of consecutive sequence-buffer words (forward or reverse,
// wrapping at the buffer end) to a ready/valid consumer.
import bram_qr_pkg::*;

module bram_qr_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  reverse,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  state_e                state;
  logic                  rev;
  logic [ADDR_WIDTH:0]   issue_rem;  // reads still to issue
  logic [ADDR_WIDTH:0]   pop_rem;    // words still to hand downstream
  logic                  in_flight;  // bram_addr holds an address whose data lands this cycle
  logic [1:0]            fifo_cnt;
  logic                  issue, pop;

  assign pop   = out_valid & out_ready;
  // Issue only if the FIFO can still hold every word already requested.
  assign issue = (state == S_FETCH) && (issue_rem != '0) &&
                 (({1'b0, fifo_cnt} + {2'b0, in_flight}) < (3'(FIFO_DEPTH) + {2'b0, pop}));
  assign busy     = (state != S_IDLE);
  assign out_last = out_valid && (pop_rem == (ADDR_WIDTH+1)'(1));

  bram_qr_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight),
    .push_data (bram_rdata),
    .pop       (pop),
    .valid     (out_valid),
    .head      (out_data),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rev       <= 1'b0;
      issue_rem <= '0;
      pop_rem   <= '0;
      in_flight <= 1'b0;
      done      <= 1'b0;
      bram_addr <= '0;
    end else begin
      done      <= 1'b0;
      in_flight <= issue;
      case (state)
        S_IDLE: begin
          if (start) begin
            rev     <= reverse;
            pop_rem <= length;
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              // First address is loaded here, so its data arrives next cycle.
              bram_addr <= start_addr;
              in_flight <= 1'b1;
              issue_rem <= length - (ADDR_WIDTH+1)'(1);
              state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (issue) begin
            bram_addr <= rev ? bram_addr - ADDR_WIDTH'(1) : bram_addr + ADDR_WIDTH'(1);
            issue_rem <= issue_rem - (ADDR_WIDTH+1)'(1);
          end
          if (issue_rem == '0 || (issue && issue_rem == (ADDR_WIDTH+1)'(1)))
            state <= S_DRAIN;
        end
        S_DRAIN: state <= S_DRAIN;
        default: state <= S_IDLE;
      endcase
      if (pop) begin
        pop_rem <= pop_rem - (ADDR_WIDTH+1)'(1);
        if (pop_rem == (ADDR_WIDTH+1)'(1)) begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_qr_reader.sv
// Directed bench for bram_qr_reader: scoreboard of expected words, checked as
// the consumer accepts them, plus latency/handshake/reset checks.
module tb_bram_qr_reader;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          reverse = 1'b0;
  logic          out_ready = 1'b1;
  logic          busy, done, out_valid, out_last;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata, out_data;

  logic [DW-1:0] mem [16];
  assign bram_rdata = mem[bram_addr];

  bram_qr_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .length(length), .reverse(reverse), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_rdata(bram_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  logic [DW:0] exp_q[$];
  int  first_v, last_pop, done_c, valid_cnt, pops, sc;
  bit  mon_on = 1'b0, tog = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Consumer-side pattern: always ready, or ready one cycle in three.
  initial forever begin
    @(posedge clk); #1;
    out_ready = tog ? (cyc % 3 == 0) : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      logic [DW:0] e;
      if (out_valid) valid_cnt++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) chk("unexpected_word", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("data", 32'(out_data), 32'(e[DW-1:0]));
          chk("last", 32'(out_last), 32'(e[DW]));
        end
        if (!tog && last_pop >= 0) chk("stream_gap", 32'(cyc - last_pop), 32'd1);
        last_pop = cyc;
      end else if (out_valid) chk("last_only_on_pop_or_hold", 32'(out_last && exp_q.size() != 1), 32'd0);
      if (done) begin
        done_c = cyc;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic kick(input int addr, input int len, input bit rev);
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      a = rev ? AW'(addr - i) : AW'(addr + i);
      exp_q.push_back({(i == len - 1), DW'(a)});
    end
    first_v = -1; last_pop = -1; done_c = -1; valid_cnt = 0; pops = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(addr); length = (AW+1)'(len); reverse = rev;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (len != 0) chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic finish(input int len, input bit stream);
    for (int k = 0; k < 300 && done_c < 0; k++) @(posedge clk);
    chk("done_seen", 32'(done_c >= 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("word_count", 32'(pops), 32'(len));
    if (len == 0) begin
      chk("len0_done_lat", 32'(done_c - sc), 32'd1);
      chk("len0_no_valid", 32'(valid_cnt), 32'd0);
    end else begin
      chk("done_lat", 32'(done_c - last_pop), 32'd1);
      if (stream) chk("first_lat", 32'(first_v - sc), 32'd2);
    end
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_on = 1'b1;

    kick(3, 4, 1'b0);  finish(4, 1'b1);
    chk("addr_hold_fwd", 32'(bram_addr), 32'd6);
    kick(1, 4, 1'b1);  finish(4, 1'b1);
    chk("addr_hold_rev", 32'(bram_addr), 32'd14);

    tog = 1'b1;
    kick(10, 5, 1'b0); finish(5, 1'b0);
    tog = 1'b0;
    repeat (2) @(posedge clk);

    kick(7, 0, 1'b0);  finish(0, 1'b0);
    kick(5, 16, 1'b0); finish(16, 1'b1);
    chk("addr_hold_full", 32'(bram_addr), 32'd4);
    kick(9, 1, 1'b1);  finish(1, 1'b1);

    // Start pulse while busy must not disturb the running tile.
    kick(3, 4, 1'b0);
    start = 1'b1; start_addr = AW'(12); length = (AW+1)'(2); reverse = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish(4, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("ignored_start_words", 32'(valid_cnt), 32'd4);

    // Reset in the middle of a tile.
    kick(0, 8, 1'b0);
    for (int k = 0; k < 100 && pops < 2; k++) @(negedge clk);
    chk("mid_pops", 32'(pops), 32'd2);
    mon_on = 1'b0; prev_stall = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_addr", 32'(bram_addr), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_on = 1'b1;
    kick(8, 2, 1'b0);  finish(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
